dmem_access_unit: RTL and testbench
===================================

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: the maximum number of ACCESS cycles without dmem_resp before abort (1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-low; rst=0 at a rising clk edge resets the block.
REQ-004 The block SHALL have ports req_valid, req_load and req_store, each input, 1 bit: the EX/MEM stage holds a valid memory instruction, and it is a load or a store respectively.
REQ-005 The block SHALL have port req_funct3, input, 3 bits: the RV32I load/store funct3 (lb, lh, lw, lbu, lhu, sb, sh, sw).
REQ-006 The block SHALL have ports req_addr and req_wdata, each input, 32 bits: the ALU effective address and the rs2 store value.
REQ-007 The block SHALL have ports dmem_read and dmem_write, each output, 1 bit: the memory read and write strobes.
REQ-008 The block SHALL have ports dmem_address and dmem_wdata, each output, 32 bits: the word-aligned address ({req_addr[31:2],2'b00}) and the lane-replicated store data.
REQ-009 The block SHALL have port dmem_mbe, output, 4 bits: the byte enables.
REQ-010 The block SHALL have ports dmem_resp, input, 1 bit, and dmem_rdata, input, 32 bits: the completion strobe and the read data.
REQ-011 The block SHALL have port stall, output, 1 bit: freeze the PC/IF/ID/EX/MEM registers this cycle.
REQ-012 The block SHALL have port load_data, output, 32 bits: the aligned, extended load result for MEM/WB.
REQ-013 The block SHALL have ports misaligned and timeout, each output, 1 bit: one-cycle error pulses.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-015 In IDLE, a request (req_valid and exactly one of req_load/req_store) that is aligned SHALL cause transition to ACCESS, and stall=1 combinationally in that IDLE cycle.
REQ-016 Alignment SHALL require lw/sw addr[1:0]=00 and lh/lhu/sh addr[0]=0; byte accesses are always aligned.
REQ-017 A misaligned request in IDLE SHALL issue no access, pulse misaligned=1 for that cycle, keep stall=0, and leave the FSM in IDLE.
REQ-018 req_load and req_store both 1 SHALL be treated as misaligned.
REQ-019 In ACCESS, dmem_read (load) or dmem_write (store) SHALL be 1, with dmem_address, dmem_wdata and dmem_mbe held constant, and stall=1.
REQ-020 In ACCESS with dmem_resp=1, the FSM SHALL register load_data and the cycle count, go to DONE, and keep stall=1 in that cycle.
REQ-021 In DONE, stall=0, dmem_read=dmem_write=0 and load_data SHALL be valid; inputs are ignored; the next state is IDLE unconditionally.
REQ-022 Minimum latency SHALL be 3 cycles from request-present to pipeline advance (IDLE, ACCESS with resp, DONE).
REQ-023 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; when it reaches TIMEOUT_CYCLES without resp, the block SHALL drop strobes, pulse timeout, set load_data=0 and go to DONE.
REQ-024 Byte enables SHALL be: sw 1111; sh 0011<<(2*addr[1]); sb 0001<<addr[1:0]; loads 1111.
REQ-025 Store data SHALL be: sw rs2; sh {2{rs2[15:0]}}; sb {4{rs2[7:0]}}.
REQ-026 Loads SHALL select the byte or halfword at offset addr[1:0] of dmem_rdata; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-027 dmem_resp in IDLE or DONE SHALL be ignored.
REQ-028 Outputs other than stall/misaligned SHALL come from registered state, not from req_* directly, except in the IDLE cycle.

Reset
REQ-029 rst=0 SHALL force IDLE, counter=0, load_data=0, and all strobes, stall, misaligned and timeout to 0 on the next edge, including mid-ACCESS; the aborted access is not retried.
REQ-030 After rst returns to 1, a still-present request SHALL restart from IDLE as new.

Verification
REQ-031 lb, addr=0x1003, rdata=0x80FF_0000, resp after 2 cycles -> dmem_address=0x1000, mbe=1111, load_data=0xFFFF_FF80, stall high 4 cycles.
REQ-032 sh, addr=0x2002, rs2=0x1234_ABCD -> dmem_write=1, mbe=1100, dmem_wdata=0xABCD_ABCD, held until resp.
REQ-033 lw, addr=0x3001 -> misaligned pulse 1 cycle, no dmem_read, stall=0.
REQ-034 TIMEOUT_CYCLES=4, resp never -> timeout pulse after 4 ACCESS cycles, then DONE with load_data=0, then IDLE.
REQ-035 rst=0 during ACCESS with a concurrent resp -> IDLE next edge, load_data=0, strobes 0; a resp after reset is ignored.
REQ-036 lhu addr=0x4002, rdata=0xBEEF_0000 -> load_data=0x0000_BEEF.

Source files
------------

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : dmem_access_unit
// Brief   : RV32I load/store data-memory sequencer with alignment check,
//           byte-lane steering, load extension and response timeout.
// Rev     : 1.0
// ============================================================================
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_ACCESS  = 2'd1;
    localparam logic [1:0]  c_DONE    = 2'd2;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic [15:0] r_count;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [31:0] r_wdata;
    logic [3:0]  r_mbe;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [31:0] r_load_data;
    logic        r_timeout;

    logic        w_one_op;
    logic        w_both_op;
    logic        w_aligned;
    logic        w_idle;
    logic        w_start;
    logic        w_misaligned;
    logic [15:0] w_count_next;
    logic [3:0]  w_mbe;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    assign w_one_op  = req_load ^ req_store;
    assign w_both_op = req_load & req_store;

    always_comb begin
        w_aligned = 1'b1;
        case (req_funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~req_addr[0];
            default: w_aligned = (req_addr[1:0] == 2'b00);
        endcase
    end

    // The IDLE-cycle decode is combinational so the pipeline freezes in the
    // same cycle the request appears; it is masked while reset is held.
    assign w_idle       = rst & (r_state == c_IDLE) & req_valid;
    assign w_start      = w_idle & w_one_op & w_aligned;
    assign w_misaligned = w_idle & (w_both_op | (w_one_op & ~w_aligned));
    assign w_count_next = r_count + 16'd1;

    always_comb begin
        w_mbe   = 4'b1111;
        w_wdata = req_wdata;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    w_mbe   = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    w_mbe   = 4'b0011 << {req_addr[1], 1'b0};
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_mbe   = 4'b1111;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_offset)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_count     <= 16'd0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= 32'd0;
            r_wdata     <= 32'd0;
            r_mbe       <= 4'd0;
            r_funct3    <= 3'd0;
            r_offset    <= 2'd0;
            r_load_data <= 32'd0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_start) begin
                        r_state   <= c_ACCESS;
                        r_count   <= 16'd0;
                        r_read    <= req_load;
                        r_write   <= req_store;
                        r_address <= {req_addr[31:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_mbe     <= w_mbe;
                        r_funct3  <= req_funct3;
                        r_offset  <= req_addr[1:0];
                    end
                end
                c_ACCESS: begin
                    r_count <= w_count_next;
                    if (dmem_resp) begin
                        r_load_data <= w_load_ext;
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_state     <= c_DONE;
                    end else if (w_count_next == c_TIMEOUT) begin
                        r_load_data <= 32'd0;
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_timeout <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign dmem_read    = r_read;
    assign dmem_write   = r_write;
    assign dmem_address = r_address;
    assign dmem_wdata   = r_wdata;
    assign dmem_mbe     = r_mbe;
    assign load_data    = r_load_data;
    assign timeout      = r_timeout;
    assign stall        = w_start | (r_state == c_ACCESS);
    assign misaligned   = w_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_access_unit
// Brief   : Directed self-checking bench with a cycle-level reference model.
// Rev     : 1.0
// ============================================================================
module tb_dmem_access_unit;

    localparam int c_TO = 4;
    localparam int c_IDLE = 0, c_ACCESS = 1, c_DONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, dmem_rdata = 32'd0;
    logic        dmem_resp = 1'b0;
    logic        dmem_read, dmem_write, stall, misaligned, timeout;
    logic [31:0] dmem_address, dmem_wdata, load_data;
    logic [3:0]  dmem_mbe;

    dmem_access_unit #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .stall(stall),
        .load_data(load_data), .misaligned(misaligned), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_aligned(input logic [31:0] a, input logic [2:0] f3);
        return (int'(a[1:0]) % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_mbe(input logic [2:0] f3, input logic [31:0] a, input logic ld);
        logic [3:0] m;
        if (ld) return 4'hF;
        m = 4'((1 << nbytes(f3)) - 1);
        return m << a[1:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v, mask;
        int n;
        n = nbytes(f3);
        v = rd >> (8 * int'(a[1:0]));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = v & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model: tracks the transaction in flight, not the DUT's registers.
    int          m_phase = c_IDLE;
    int          m_elapsed = 0;
    logic        m_is_load = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_ld = 32'd0;
    logic [2:0]  m_f3 = 3'd0;
    logic        m_to = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase <= c_IDLE;
            m_ld    <= 32'd0;
            m_to    <= 1'b0;
        end else if (m_phase == c_IDLE) begin
            m_to <= 1'b0;
            if (req_valid && (req_load != req_store) && is_aligned(req_addr, req_funct3)) begin
                m_phase   <= c_ACCESS;
                m_elapsed <= 0;
                m_is_load <= req_load;
                m_addr    <= req_addr;
                m_f3      <= req_funct3;
                m_wdata   <= req_wdata;
            end
        end else if (m_phase == c_ACCESS) begin
            if (dmem_resp) begin
                m_ld    <= exp_load(m_f3, m_addr, dmem_rdata);
                m_phase <= c_DONE;
            end else if (m_elapsed + 1 == c_TO) begin
                m_ld    <= 32'd0;
                m_to    <= 1'b1;
                m_phase <= c_DONE;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end else begin
            m_to    <= 1'b0;
            m_phase <= c_IDLE;
        end
    end

    always @(negedge clk) begin
        logic one, both, al, e_start, e_mis;
        one     = req_load != req_store;
        both    = req_load && req_store;
        al      = is_aligned(req_addr, req_funct3);
        e_start = rst && m_phase == c_IDLE && req_valid && one && al;
        e_mis   = rst && m_phase == c_IDLE && req_valid && (both || (one && !al));
        chk("stall", {31'd0, stall}, {31'd0, e_start || m_phase == c_ACCESS});
        chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
        chk("dmem_read", {31'd0, dmem_read}, {31'd0, m_phase == c_ACCESS && m_is_load});
        chk("dmem_write", {31'd0, dmem_write}, {31'd0, m_phase == c_ACCESS && !m_is_load});
        chk("timeout", {31'd0, timeout}, {31'd0, m_to});
        if (m_phase == c_ACCESS) begin
            chk("dmem_address", dmem_address, {m_addr[31:2], 2'b00});
            chk("dmem_mbe", {28'd0, dmem_mbe}, {28'd0, exp_mbe(m_f3, m_addr, m_is_load)});
            if (!m_is_load) chk("dmem_wdata", dmem_wdata, exp_wdata(m_f3, m_wdata));
        end
        if (m_phase == c_DONE) chk("load_data", load_data, m_ld);
    end

    int          o_stalls, o_reads, o_writes, o_tos, o_mis;
    logic [31:0] o_addr1, o_wdata1, o_ld;
    logic [3:0]  o_mbe1;

    // Holds the request until the DONE cycle has passed; resp arrives after
    // `waits` ACCESS cycles (never if negative) and stays up through DONE.
    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
        int len;
        len = (waits < 0) ? c_TO + 2 : waits + 3;
        o_stalls = 0; o_reads = 0; o_writes = 0; o_tos = 0; o_mis = 0;
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; dmem_rdata = rd;
        for (int c = 0; c < len; c++) begin
            dmem_resp = (waits >= 0) && (c >= waits + 1);
            @(negedge clk);
            o_stalls += int'(stall);
            o_reads  += int'(dmem_read);
            o_writes += int'(dmem_write);
            o_tos    += int'(timeout);
            o_mis    += int'(misaligned);
            if (c == 1) begin
                o_addr1 = dmem_address; o_mbe1 = dmem_mbe; o_wdata1 = dmem_wdata;
            end
            if (c == len - 1) o_ld = load_data;
            @(posedge clk); #2;
        end
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; dmem_resp = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic mis_pulse(input string name, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] addr);
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3; req_addr = addr;
        @(negedge clk);
        chk({name, "_mis"}, {31'd0, misaligned}, 32'd1);
        chk({name, "_stall"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        @(negedge clk);
        chk({name, "_noread"}, {31'd0, dmem_read | dmem_write}, 32'd0);
        chk({name, "_mis_end"}, {31'd0, misaligned}, 32'd0);
        @(posedge clk); #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        do_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 2);
        chk("lb_stall_cycles", 32'(o_stalls), 32'd4);
        chk("lb_read_cycles", 32'(o_reads), 32'd3);
        chk("lb_address", o_addr1, 32'h0000_1000);
        chk("lb_mbe", {28'd0, o_mbe1}, 32'hF);
        chk("lb_load_data", o_ld, 32'hFFFF_FF80);

        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 1);
        chk("sh_write_cycles", 32'(o_writes), 32'd2);
        chk("sh_mbe", {28'd0, o_mbe1}, 32'hC);
        chk("sh_wdata", o_wdata1, 32'hABCD_ABCD);
        chk("sh_no_read", 32'(o_reads), 32'd0);

        mis_pulse("lw_3001", 1'b1, 1'b0, 3'b010, 32'h0000_3001);
        mis_pulse("ld_and_st", 1'b1, 1'b1, 3'b010, 32'h0000_3000);
        mis_pulse("lh_0005", 1'b1, 1'b0, 3'b001, 32'h0000_0005);

        do_txn(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'd0, 32'hBEEF_0000, 0);
        chk("lhu_load_data", o_ld, 32'h0000_BEEF);
        chk("lhu_stall_cycles", 32'(o_stalls), 32'd2);

        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'h5555_5555, -1);
        chk("to_stall_cycles", 32'(o_stalls), 32'd5);
        chk("to_read_cycles", 32'(o_reads), 32'd4);
        chk("to_pulses", 32'(o_tos), 32'd1);
        chk("to_load_data", o_ld, 32'd0);

        do_txn(1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 32'd0, 0);
        chk("sb_mbe", {28'd0, o_mbe1}, 32'h2);
        chk("sb_wdata", o_wdata1, 32'hA5A5_A5A5);

        do_txn(1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'd0, 32'h0000_8001, 1);
        chk("lh_load_data", o_ld, 32'hFFFF_8001);

        do_txn(1'b1, 1'b0, 3'b100, 32'h0000_0006, 32'd0, 32'h00F7_0000, 0);
        chk("lbu_load_data", o_ld, 32'h0000_00F7);

        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'd0, 0);
        chk("sw_mbe", {28'd0, o_mbe1}, 32'hF);
        chk("sw_wdata", o_wdata1, 32'hDEAD_BEEF);

        // Reset lands in ACCESS together with a response.
        req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_5000;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678; req_valid = 1'b0; req_load = 1'b0;
        @(negedge clk);
        chk("rstacc_read_before_edge", {31'd0, dmem_read}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rstacc_read", {31'd0, dmem_read}, 32'd0);
        chk("rstacc_stall", {31'd0, stall}, 32'd0);
        chk("rstacc_load_data", load_data, 32'd0);
        @(posedge clk); #2;
        @(negedge clk);
        chk("rstacc_resp_ignored", load_data, 32'd0);
        chk("rstacc_still_idle", {31'd0, dmem_read}, 32'd0);
        @(posedge clk); #2;
        dmem_resp = 1'b0;

        // Request held across a reset restarts as a fresh access.
        req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0040;
        rst = 1'b0;
        @(negedge clk);
        chk("held_req_in_reset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 0);
        chk("restart_load_data", o_ld, 32'hCAFE_F00D);
        chk("restart_stall_cycles", 32'(o_stalls), 32'd2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
